// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
//   Memory-side responder for the pipeline data-memory request interface.
//   Accepts one load/store at a time (valid/ready), waits LATENCY cycles,
//   performs a byte/half/word access with sign or zero extension, and returns
//   a one-cycle response strobe.
//
// Parameters
//   DEPTH_LOG2 : number of word-address bits (2^DEPTH_LOG2 32-bit words)
//   LATENCY    : WAIT cycles between accept and response (>= 1)
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset (clears memory, forces IDLE)
//   req_valid  : request present
//   req_ready  : responder can accept (decode of IDLE)
//   req_we     : 1 = store, 0 = load
//   req_addr   : byte address
//   req_wdata  : store data, right-aligned
//   req_op     : 000 word, 001 byte u, 010 byte s, 011 half u, 100 half s
//   req_pc     : PC of the issuing instruction (trace only)
//   resp_valid : one-cycle response strobe
//   resp_rdata : extended load data; 0 for stores and errors
//   resp_err   : request rejected (misaligned, out of range, illegal op)
//
// Configuration
//   DM_RESPONDER_TRACE_EN : when defined, each non-error store commit prints
//                           "<time>@<pc>: *<word addr> <= <merged word>".
// -----------------------------------------------------------------------------
module dm_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] OP_W  = 3'd0;
    localparam logic [2:0] OP_BU = 3'd1;
    localparam logic [2:0] OP_BS = 3'd2;
    localparam logic [2:0] OP_HU = 3'd3;
    localparam logic [2:0] OP_HS = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        op_q;
    logic [31:0]       pc_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;
    logic [31:0]       mem_q [WORDS];

    logic [DEPTH_LOG2-1:0] word_idx_d;
    logic [31:0]           old_word_d;
    logic [31:0]           merged_d;
    logic [31:0]           load_d;
    logic                  err_d;
    logic                  commit_d;
    logic                  wr_en_d;

    // Rejection rule: illegal op, misaligned word/half, or address beyond memory.
    function automatic logic req_error(input logic [31:0] addr, input logic [2:0] op);
        logic e;
        case (op)
            OP_W:          e = (addr[1:0] != 2'b00);
            OP_BU, OP_BS:  e = 1'b0;
            OP_HU, OP_HS:  e = addr[0];
            default:       e = 1'b1;
        endcase
        if ((addr >> (DEPTH_LOG2 + 2)) != 32'd0) begin
            e = 1'b1;
        end
        return e;
    endfunction

    // Merge right-aligned store data into the addressed lane(s) of a word.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  op,
                                                input logic [1:0]  lane);
        logic [31:0] w;
        w = old_word;
        case (op)
            OP_W:         w = wdata;
            OP_BU, OP_BS: w[{lane, 3'b000} +: 8]        = wdata[7:0];
            OP_HU, OP_HS: w[{lane[1], 4'b0000} +: 16]   = wdata[15:0];
            default:      w = old_word;
        endcase
        return w;
    endfunction

    // Select the addressed lane(s) and extend to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  op,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (op)
            OP_W:    r = word;
            OP_BU:   r = {24'd0, b};
            OP_BS:   r = {{24{b[7]}}, b};
            OP_HU:   r = {16'd0, h};
            OP_HS:   r = {{16{h[15]}}, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Commit-edge datapath computed from the latched request.
    always_comb begin
        word_idx_d = addr_q[DEPTH_LOG2+1:2];
        old_word_d = mem_q[word_idx_d];
        err_d      = req_error(addr_q, op_q);
        merged_d   = merge_store(old_word_d, wdata_q, op_q, addr_q[1:0]);
        load_d     = extract_load(old_word_d, op_q, addr_q[1:0]);
        commit_d   = (state_q == ST_WAIT) && (cnt_q == CNT_ONE);
        wr_en_d    = commit_d && we_q && !err_d;
    end

    // Storage array; the write lands on the same edge the response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (wr_en_d) begin
            mem_q[word_idx_d] <= merged_d;
        end
    end

    // Request/response FSM with registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            op_q         <= 3'd0;
            pc_q         <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        op_q    <= req_op;
                        pc_q    <= req_pc;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_ONE) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_d;
                        // Stores and rejected requests return zero data.
                        resp_rdata_q <= (err_d || we_q) ? 32'd0 : load_d;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

`ifdef DM_RESPONDER_TRACE_EN
    // Store trace; an aborted request never reaches its commit edge.
    always @(posedge clk) begin
        if (!reset && wr_en_d) begin
            $display("%d@%h: *%h <= %h", $time, pc_q, {addr_q[31:2], 2'b00}, merged_d);
        end
    end
`else
    // The latched PC only feeds the trace.
    logic unused_pc_s;
    assign unused_pc_s = ^pc_q;
`endif

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic        clk = 1'b0;
    logic        reset;

    logic        v0, rdy0, we0, rv0, er0;
    logic [31:0] a0, wd0, pc0, rd0;
    logic [2:0]  op0;

    logic        v1, rdy1, we1, rv1, er1;
    logic [31:0] a1, wd1, pc1, rd1;
    logic [2:0]  op1;

    int checks   = 0;
    int failures = 0;

    // Byte-granular reference memory (16 KiB = 4096 words).
    logic [7:0] mb [16384];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  op;
        logic [31:0] rdata;
        logic        err;
        string       name;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_LOG2(12), .LATENCY(LAT0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(v0), .req_ready(rdy0), .req_we(we0), .req_addr(a0),
        .req_wdata(wd0), .req_op(op0), .req_pc(pc0),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0)
    );

    dm_responder #(.DEPTH_LOG2(12), .LATENCY(LAT1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(v1), .req_ready(rdy1), .req_we(we1), .req_addr(a1),
        .req_wdata(wd1), .req_op(op1), .req_pc(pc1),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] op, input logic [31:0] rdata, input logic err,
                       input string name);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.op = op;
        v.rdata = rdata; v.err = err; v.name = name;
        tbl.push_back(v);
    endtask

    function automatic logic model_err(input logic [31:0] a, input logic [2:0] op);
        if (op > 3'd4)         return 1'b1;
        if (a >= 32'h0000_4000) return 1'b1;
        if (op == 3'd0)        return (a % 4) != 0;
        if (op >= 3'd3)        return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic int model_size(input logic [2:0] op);
        if (op == 3'd0) return 4;
        if (op <= 3'd2) return 1;
        return 2;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16384; i++) mb[i] = 8'd0;
    endtask

    task automatic model_apply(input logic we, input logic [31:0] a, input logic [31:0] wd,
                               input logic [2:0] op, output logic [31:0] rd, output logic er);
        int sz;
        er = model_err(a, op);
        rd = 32'd0;
        if (!er) begin
            sz = model_size(op);
            if (we) begin
                for (int i = 0; i < sz; i++) mb[int'(a) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++) rd = rd | (32'(mb[int'(a) + i]) << (8*i));
                if (op == 3'd2 && rd[7])  rd = rd | 32'hFFFF_FF00;
                if (op == 3'd4 && rd[15]) rd = rd | 32'hFFFF_0000;
            end
        end
    endtask

    // Issue one request on dut0 (called at a negedge); returns response and latency.
    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] op, output logic [31:0] rd, output logic er,
                          output int lat);
        int n;
        lat = -1; rd = 32'd0; er = 1'b0; n = 0;
        while (!rdy0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        we0 = we; a0 = a; wd0 = wd; op0 = op; pc0 = $urandom; v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (rv0) begin
                lat = c; rd = rd0; er = er0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run(input string name, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] op, input logic use_exp,
                       input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] mrd, rd;
        logic        mer, er;
        int          lat;
        model_apply(we, a, wd, op, mrd, mer);
        if (!use_exp) begin
            exp_rd = mrd;
            exp_er = mer;
        end
        do_req(we, a, wd, op, rd, er, lat);
        check({name, " latency"}, 32'(lat), 32'(LAT0 + 1));
        check({name, " rdata"}, rd, exp_rd);
        check({name, " err"}, 32'(er), 32'(exp_er));
    endtask

    // Hold req_valid on dut1 for four back-to-back requests (LATENCY=1).
    task automatic held(input logic we);
        int  k, acc, pulses;
        logic prev;
        @(negedge clk);
        k = 0; acc = 0; pulses = 0; prev = 1'b0;
        we1 = we; a1 = 32'd0; wd1 = 32'h1111_1111; op1 = 3'd0; pc1 = 32'd0; v1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (prev) begin
                k++;
                a1  = 32'(4 * k);
                wd1 = 32'h1111_1111 * 32'(k + 1);
                if (k == 4) v1 = 1'b0;
            end
            check("held ready", 32'(rdy1), 32'(i % 3 == 0));
            check("held resp_valid", 32'(rv1), 32'(i % 3 == 2));
            if (rv1) begin
                pulses++;
                check("held rdata", rd1, we ? 32'd0 : 32'h1111_1111 * 32'(i / 3 + 1));
                check("held err", 32'(er1), 32'd0);
            end
            prev = rdy1 && v1;
            if (prev) acc++;
        end
        v1 = 1'b0;
        check("held pulses", 32'(pulses), 32'd4);
        check("held accepts", 32'(acc), 32'd4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, wd;
        logic [2:0]  op;
        int          r;

        reset = 1'b1;
        v0 = 1'b0; we0 = 1'b0; a0 = 32'd0; wd0 = 32'd0; op0 = 3'd0; pc0 = 32'd0;
        v1 = 1'b0; we1 = 1'b0; a1 = 32'd0; wd1 = 32'd0; op1 = 3'd0; pc1 = 32'd0;
        model_clear();

        add(1'b1, 32'h10,   32'h1234_5678, 3'd0, 32'h0000_0000, 1'b0, "st_w_10");
        add(1'b0, 32'h10,   32'd0,         3'd0, 32'h1234_5678, 1'b0, "ld_w_10");
        add(1'b1, 32'h13,   32'h0000_00AB, 3'd1, 32'h0000_0000, 1'b0, "st_b_13");
        add(1'b0, 32'h10,   32'd0,         3'd0, 32'hAB34_5678, 1'b0, "ld_w_10b");
        add(1'b0, 32'h13,   32'd0,         3'd2, 32'hFFFF_FFAB, 1'b0, "ld_bs_13");
        add(1'b0, 32'h13,   32'd0,         3'd1, 32'h0000_00AB, 1'b0, "ld_bu_13");
        add(1'b1, 32'h12,   32'h0000_8001, 3'd3, 32'h0000_0000, 1'b0, "st_h_12");
        add(1'b0, 32'h12,   32'd0,         3'd4, 32'hFFFF_8001, 1'b0, "ld_hs_12");
        add(1'b0, 32'h12,   32'd0,         3'd3, 32'h0000_8001, 1'b0, "ld_hu_12");
        add(1'b0, 32'h11,   32'd0,         3'd0, 32'h0000_0000, 1'b1, "ld_w_mis");
        add(1'b1, 32'h13,   32'h0000_BEEF, 3'd3, 32'h0000_0000, 1'b1, "st_h_mis");
        add(1'b0, 32'h10,   32'd0,         3'd7, 32'h0000_0000, 1'b1, "ld_op7");
        add(1'b0, 32'h4000, 32'd0,         3'd0, 32'h0000_0000, 1'b1, "ld_range");
        add(1'b1, 32'h4000, 32'hDEAD_BEEF, 3'd0, 32'h0000_0000, 1'b1, "st_range");
        add(1'b0, 32'h10,   32'd0,         3'd0, 32'h8001_5678, 1'b0, "ld_w_unch");
        add(1'b0, 32'h0,    32'd0,         3'd0, 32'h0000_0000, 1'b0, "ld_w_0");
        add(1'b1, 32'h11,   32'h0000_005A, 3'd2, 32'h0000_0000, 1'b0, "st_bs_11");
        add(1'b0, 32'h10,   32'd0,         3'd0, 32'h8001_5A78, 1'b0, "ld_w_lane1");

        @(negedge clk);
        @(negedge clk);
        check("reset ready0", 32'(rdy0), 32'd1);
        check("reset valid0", 32'(rv0), 32'd0);
        check("reset rdata0", rd0, 32'd0);
        check("reset err0", 32'(er0), 32'd0);
        check("reset valid1", 32'(rv1), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle ready0", 32'(rdy0), 32'd1);

        foreach (tbl[i]) begin
            run(tbl[i].name, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].op, 1'b1,
                tbl[i].rdata, tbl[i].err);
        end

        held(1'b1);
        held(1'b0);

        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 15);
            op = (r < 13) ? 3'(r % 5) : 3'(5 + r % 3);
            if ($urandom_range(0, 9) == 0) a = 32'h1 << $urandom_range(14, 31);
            else                           a = 32'($urandom_range(0, 63));
            wd = $urandom;
            run("random", 1'($urandom_range(0, 1)), a, wd, op, 1'b0, 32'd0, 1'b0);
        end

        // Reset during WAIT of a store to 0x20 aborts it.
        @(negedge clk);
        we0 = 1'b1; a0 = 32'h20; wd0 = 32'hCAFE_F00D; op0 = 3'd0; v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        check("abort in wait", 32'(rdy0), 32'd0);
        reset = 1'b1;
        #1;
        check("abort ready", 32'(rdy0), 32'd1);
        check("abort valid", 32'(rv0), 32'd0);
        check("abort rdata", rd0, 32'd0);
        check("abort err", 32'(er0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post abort valid", 32'(rv0), 32'd0);
            check("post abort ready", 32'(rdy0), 32'd1);
        end
        run("ld_w_20_after_abort", 1'b0, 32'h20, 32'd0, 3'd0, 1'b1, 32'd0, 1'b0);
        run("ld_w_10_after_reset", 1'b0, 32'h10, 32'd0, 3'd0, 1'b1, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
# dm_responder

Memory-side responder for the pipeline's data-memory request interface. Accepts one load/store request at a time over a valid/ready handshake, waits a fixed access latency, performs byte/half/word access with sign or zero extension, and returns a single-cycle response. It replaces the zero-latency data memory when exercising multi-cycle memory behaviour; the CPU-side issuer stalls on `req_ready`/`resp_valid`.

## Interface
- `DEPTH_LOG2`, default 12: number of word-address bits; memory holds 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, default 2: WAIT cycles between accept and response; legal range ≥1.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_op` in 3: access-width code.
  - 000 word
  - 001 byte unsigned
  - 010 byte signed
  - 011 half unsigned
  - 100 half signed
  - 101–111 illegal
- `req_pc` in 32: PC of the issuing instruction, used for trace only.
- `resp_valid` out 1: one-cycle response strobe.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: request rejected (misaligned, out of range, or illegal op).

## Operation
- FSM states IDLE → WAIT → RESP → IDLE.
  - IDLE: `req_ready`=1. If `req_valid` is high at an edge, latch we/addr/wdata/op/pc, load counter with LATENCY, and go to WAIT.
  - WAIT: decrement counter each cycle. On the edge where counter==1: commit the access and go to RESP.
  - RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE. There is no back-pressure on the response.
- Word index is `addr[DEPTH_LOG2+1:2]`. Lanes are little-endian: byte k (`addr[1:0]`=k) occupies bits [8k+7:8k].
- Stores:
  - byte: writes `wdata[7:0]` into lane `addr[1:0]`.
  - half: writes `wdata[15:0]` into lanes {2·addr[1]+1, 2·addr[1]}.
  - word: writes the full word.
  - Other lanes are unchanged.
- Loads: select the lane(s) the same way, then sign-extend (ops 010/100) or zero-extend (001/011) to 32 bits.
- Error when any of the following holds:
  - op is illegal;
  - word access with `addr[1:0]`≠0;
  - half access with `addr[0]`≠0;
  - `addr[31:DEPTH_LOG2+2]`≠0.
- On error: no memory write; `resp_rdata`=0; `resp_err`=1 alongside `resp_valid`.
- Reset:
  - clears all memory words to 0;
  - forces IDLE;
  - drives `resp_valid`=0, `resp_rdata`=0, `resp_err`=0;
  - any latched request whose commit edge has not occurred is discarded.
- Requests presented while not in IDLE are ignored. The issuer holds them until `req_ready` is seen.

## Timing
- Accept edge at end of cycle n → WAIT in cycles n+1..n+LATENCY → RESP in cycle n+LATENCY+1 → IDLE in cycle n+LATENCY+2.
- Minimum request spacing is LATENCY+2 cycles.
- Memory update and `resp_rdata`/`resp_err` are registered on the same edge (WAIT→RESP). A load's data is therefore valid exactly during the `resp_valid` cycle. A load issued right after a store to the same word sees the new data.
- `req_ready` is a combinational decode of state IDLE. It reads 1 while reset is asserted, but no handshake is taken during reset.
- `resp_rdata`/`resp_err` hold their values after RESP until the next commit. Only `resp_valid` qualifies them.
- Reset deassertion takes effect at the next rising edge. An asynchronous assert in WAIT aborts immediately.

## Configuration
- `DM_RESPONDER_TRACE_EN` defined: at each non-error store commit, print `"%d@%h: *%h <= %h"` with $time, latched pc, word-aligned byte address, and the merged 32-bit word. No print for loads or errors.
- Undefined: no simulation output. Functional behaviour is identical.

## Test plan
- Reset, then store word 0x12345678 at 0x10 (LATENCY=2) → `resp_valid` exactly 3 cycles after accept, `resp_err`=0. Load word at 0x10 → `resp_rdata`=0x12345678.
- Store byte 0xAB (op 001) at 0x13 over that word, then load word 0x10 → 0xAB345678. Load byte signed at 0x13 → 0xFFFFFFAB. Load byte unsigned → 0x000000AB.
- Store half 0x8001 at 0x12, then load half signed at 0x12 → 0xFFFF8001. Load half unsigned → 0x00008001.
- Misaligned word load at 0x11, half store at 0x13, op 111, and address 0x4000 (DEPTH_LOG2=12) → each responds with `resp_err`=1 and `resp_rdata`=0, and memory is unchanged.
- Hold `req_valid` continuously with LATENCY=1 → `req_ready` high only every 3rd cycle. Each request gets exactly one `resp_valid` pulse, in order.
- Assert `reset` during WAIT of a store to 0x20 → no `resp_valid`, IDLE next cycle, and a later load of 0x20 returns 0. With `DM_RESPONDER_TRACE_EN`, no trace line is printed for the aborted store.
